load_store_unit: RTL and testbench

//  Sits between the single-cycle core's ALU/control and the word-wide DataMemory (1K x32, index Address[11:2],

---
 rtl/lsu_pkg.sv | 33 +++
 rtl/lsu_lane_align.sv | 66 ++++++
 rtl/load_store_unit.sv | 119 +++++++++++
 tb/tb_load_store_unit.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// ----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit:
//   - access size encodings (SZ_BYTE / SZ_HALF / SZ_WORD, 2'b11 is illegal)
//   - FSM state type lsu_state_t
//   - is_misaligned(): alignment check for a size / low address pair
// ----------------------------------------------------------------------------
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } lsu_state_t;

    // The illegal size 2'b11 is folded into the misaligned class so that it
    // gets rejected through the same path.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// ----------------------------------------------------------------------------
// lsu_lane_align
// Pure combinational little-endian lane handling.
//   Loads : pick the byte/half at lane from rword and zero/sign-extend it;
//           words pass through unchanged.
//   Stores: insert wdata[7:0] / wdata[15:0] into rword at lane (merge word
//           for the read-modify-write sequence).
// Ports:
//   size        in   access size (lsu_pkg encodings)
//   ld_unsigned in   1 = zero-extend, 0 = sign-extend
//   lane        in   byte lane (address bits [1:0])
//   rword       in   word read from memory
//   wdata       in   right-justified store data
//   load_data   out  extended load result
//   merge_data  out  rword with store data inserted
// ----------------------------------------------------------------------------
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [1:0]        size,
    input  logic              ld_unsigned,
    input  logic [1:0]        lane,
    input  logic [DATA_W-1:0] rword,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] load_data,
    output logic [DATA_W-1:0] merge_data
);

    logic        [7:0]  byte_v;
    logic        [15:0] half_v;
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;

    always_comb begin
        byte_v = rword[{lane, 3'b000} +: 8];
        // Halves sit on lane 0 or lane 2; lane[0] is already known to be 0.
        half_v = rword[{lane[1], 4'b0000} +: 16];
        byte_s = byte_v;
        half_s = half_v;

        load_data = rword;
        case (size)
            SZ_BYTE: begin
                if (ld_unsigned) load_data = DATA_W'(byte_v);
                else             load_data = DATA_W'(byte_s);
            end
            SZ_HALF: begin
                if (ld_unsigned) load_data = DATA_W'(half_v);
                else             load_data = DATA_W'(half_s);
            end
            default: load_data = rword;
        endcase
    end

    always_comb begin
        merge_data = rword;
        case (size)
            SZ_BYTE: merge_data[{lane, 3'b000} +: 8]     = wdata[7:0];
            SZ_HALF: merge_data[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            default: merge_data = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// ----------------------------------------------------------------------------
// load_store_unit
// Bridges the core's byte/half/word memory ops onto a word-wide DataMemory
// (combinational read, posedge write). Loads complete in the same cycle;
// word stores in one cycle; sub-word stores use a two-cycle read-modify-write
// during which busy stalls the core for the first cycle.
// Ports:
//   Clk, Reset      clock, synchronous active-high reset
//   req_*           request from the core (held stable while busy=1)
//   busy            op not yet complete, core must hold
//   resp_rdata      extended load data (0 when no valid load)
//   misalign_err    request rejected this cycle
//   Mem*            DataMemory interface (word-aligned address)
// ----------------------------------------------------------------------------
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              busy,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              misalign_err,
    output logic [ADDR_W-1:0] MemAddress,
    output logic [DATA_W-1:0] MemWriteData,
    output logic              MemWrite,
    output logic              MemRead,
    input  logic [DATA_W-1:0] MemReadData
);

    lsu_state_t        state_q, state_d;
    logic [DATA_W-1:0] merge_data_p1;
    logic [ADDR_W-1:0] merge_addr_p1;

    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] merge_data;
    logic [ADDR_W-1:0] word_addr;
    logic              misaligned;

    assign word_addr  = {req_addr[ADDR_W-1:2], 2'b00};
    assign misaligned = is_misaligned(req_size, req_addr[1:0]);

    lsu_lane_align #(
        .DATA_W (DATA_W)
    ) u_align (
        .size        (req_size),
        .ld_unsigned (req_unsigned),
        .lane        (req_addr[1:0]),
        .rword       (MemReadData),
        .wdata       (req_wdata),
        .load_data   (load_data),
        .merge_data  (merge_data)
    );

    // Stage p0 -> p1: state, merge word and word address for the RMW write.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q       <= IDLE;
            merge_data_p1 <= '0;
            merge_addr_p1 <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && state_d == RMW_WR) begin
                merge_data_p1 <= merge_data;
                merge_addr_p1 <= word_addr;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        busy         = 1'b0;
        resp_rdata   = '0;
        misalign_err = 1'b0;
        MemAddress   = word_addr;
        MemWriteData = req_wdata;
        MemWrite     = 1'b0;
        MemRead      = 1'b0;

        // Reset gates every control output, so an RMW write in flight is
        // dropped rather than committed on the reset edge.
        if (!Reset) begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        if (misaligned) begin
                            misalign_err = 1'b1;
                        end else if (!req_write) begin
                            MemRead    = 1'b1;
                            resp_rdata = load_data;
                        end else if (req_size == SZ_WORD) begin
                            MemWrite = 1'b1;
                        end else begin
                            MemRead = 1'b1;
                            busy    = 1'b1;
                            state_d = RMW_WR;
                        end
                    end
                end
                RMW_WR: begin
                    MemWrite     = 1'b1;
                    MemWriteData = merge_data_p1;
                    MemAddress   = merge_addr_p1;
                    state_d      = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        req_valid;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        busy;
    logic [31:0] resp_rdata;
    logic        misalign_err;
    logic [31:0] MemAddress;
    logic [31:0] MemWriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] MemReadData;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .req_valid    (req_valid),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .busy         (busy),
        .resp_rdata   (resp_rdata),
        .misalign_err (misalign_err),
        .MemAddress   (MemAddress),
        .MemWriteData (MemWriteData),
        .MemWrite     (MemWrite),
        .MemRead      (MemRead),
        .MemReadData  (MemReadData)
    );

    // DataMemory: 1K x 32, combinational read, posedge write.
    logic [31:0] mem [0:1023];
    assign MemReadData = mem[MemAddress[11:2]];
    always @(posedge Clk) if (MemWrite) mem[MemAddress[11:2]] <= MemWriteData;

    typedef struct {
        string       nm;
        logic        busy;
        logic        rd;
        logic        wr;
        logic        err;
        logic [31:0] rdata;
        logic [31:0] wdata;
        logic [31:0] addr;
    } exp_t;

    exp_t exp_q[$];

    // Monitor: one expectation per driven cycle, sampled mid-cycle.
    always @(negedge Clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic ok;
            e  = exp_q.pop_front();
            ok = (busy === e.busy) && (MemRead === e.rd) && (MemWrite === e.wr) &&
                 (misalign_err === e.err) && (resp_rdata === e.rdata);
            if (e.wr) ok = ok && (MemWriteData === e.wdata);
            if (e.rd || e.wr) ok = ok && (MemAddress === e.addr);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL %s: got busy=%b rd=%b wr=%b err=%b rdata=%h wdata=%h addr=%h ; want busy=%b rd=%b wr=%b err=%b rdata=%h wdata=%h addr=%h",
                         e.nm, busy, MemRead, MemWrite, misalign_err, resp_rdata, MemWriteData, MemAddress,
                         e.busy, e.rd, e.wr, e.err, e.rdata, e.wdata, e.addr);
            end
        end
    end

    task automatic cyc(input string nm, input logic rst, input logic v, input logic w,
                       input logic [1:0] sz, input logic u, input logic [31:0] a,
                       input logic [31:0] wd, input logic e_busy, input logic e_rd,
                       input logic e_wr, input logic e_err, input logic [31:0] e_rdata,
                       input logic [31:0] e_wdata, input logic [31:0] e_addr);
        exp_t e;
        @(posedge Clk);
        #1;
        Reset = rst; req_valid = v; req_write = w; req_size = sz;
        req_unsigned = u; req_addr = a; req_wdata = wd;
        e.nm = nm; e.busy = e_busy; e.rd = e_rd; e.wr = e_wr; e.err = e_err;
        e.rdata = e_rdata; e.wdata = e_wdata; e.addr = e_addr;
        exp_q.push_back(e);
    endtask

    task automatic mem_check(input string nm, input int idx, input logic [31:0] want);
        checks++;
        if (mem[idx] !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, mem[idx], want);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[16] = 32'h8022_3344;
        Reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;

        //   name         rst v  w  sz     u  addr   wdata          busy rd wr err rdata         wdata         addr
        cyc("reset_idle", 1, 0, 0, 2'b00, 0, 32'h0,  32'h0,          0, 0, 0, 0, 32'h0,        32'h0,        32'h0);
        cyc("reset_req",  1, 1, 0, 2'b00, 0, 32'h43, 32'h0,          0, 0, 0, 0, 32'h0,        32'h0,        32'h0);
        cyc("lb_43",      0, 1, 0, 2'b00, 0, 32'h43, 32'h0,          0, 1, 0, 0, 32'hFFFFFF80, 32'h0,        32'h40);
        cyc("lbu_43",     0, 1, 0, 2'b00, 1, 32'h43, 32'h0,          0, 1, 0, 0, 32'h00000080, 32'h0,        32'h40);
        cyc("lh_42",      0, 1, 0, 2'b01, 0, 32'h42, 32'h0,          0, 1, 0, 0, 32'hFFFF8022, 32'h0,        32'h40);
        cyc("lhu_40",     0, 1, 0, 2'b01, 1, 32'h40, 32'h0,          0, 1, 0, 0, 32'h00003344, 32'h0,        32'h40);
        cyc("sb_41_rd",   0, 1, 1, 2'b00, 0, 32'h41, 32'h000000AB,   1, 1, 0, 0, 32'h0,        32'h0,        32'h40);
        cyc("sb_41_wr",   0, 1, 1, 2'b00, 0, 32'h41, 32'h000000AB,   0, 0, 1, 0, 32'h0,        32'h8022AB44, 32'h40);
        cyc("lw_40_a",    0, 1, 0, 2'b10, 0, 32'h40, 32'h0,          0, 1, 0, 0, 32'h8022AB44, 32'h0,        32'h40);
        cyc("sh_42_rd",   0, 1, 1, 2'b01, 0, 32'h42, 32'hDEADBEEF,   1, 1, 0, 0, 32'h0,        32'h0,        32'h40);
        cyc("sh_42_wr",   0, 1, 1, 2'b01, 0, 32'h42, 32'hDEADBEEF,   0, 0, 1, 0, 32'h0,        32'hBEEFAB44, 32'h40);
        cyc("lw_40_b",    0, 1, 0, 2'b10, 0, 32'h40, 32'h0,          0, 1, 0, 0, 32'hBEEFAB44, 32'h0,        32'h40);
        cyc("sw_44",      0, 1, 1, 2'b10, 0, 32'h44, 32'h12345678,   0, 0, 1, 0, 32'h0,        32'h12345678, 32'h44);
        cyc("lw_44",      0, 1, 0, 2'b10, 0, 32'h44, 32'h0,          0, 1, 0, 0, 32'h12345678, 32'h0,        32'h44);
        cyc("lw_42_mis",  0, 1, 0, 2'b10, 0, 32'h42, 32'h0,          0, 0, 0, 1, 32'h0,        32'h0,        32'h0);
        cyc("sh_41_mis",  0, 1, 1, 2'b01, 0, 32'h41, 32'hFFFF,       0, 0, 0, 1, 32'h0,        32'h0,        32'h0);
        cyc("sz11_mis",   0, 1, 1, 2'b11, 0, 32'h40, 32'h1,          0, 0, 0, 1, 32'h0,        32'h0,        32'h0);
        cyc("idle",       0, 0, 1, 2'b00, 0, 32'h40, 32'h1,          0, 0, 0, 0, 32'h0,        32'h0,        32'h0);
        cyc("lw_40_c",    0, 1, 0, 2'b10, 0, 32'h40, 32'h0,          0, 1, 0, 0, 32'hBEEFAB44, 32'h0,        32'h40);
        cyc("sb_rst_rd",  0, 1, 1, 2'b00, 0, 32'h40, 32'h00000055,   1, 1, 0, 0, 32'h0,        32'h0,        32'h40);
        cyc("sb_rst_wr",  1, 1, 1, 2'b00, 0, 32'h40, 32'h00000055,   0, 0, 0, 0, 32'h0,        32'h0,        32'h0);
        cyc("post_rst",   0, 0, 0, 2'b00, 0, 32'h40, 32'h0,          0, 0, 0, 0, 32'h0,        32'h0,        32'h0);
        cyc("lw_40_d",    0, 1, 0, 2'b10, 0, 32'h40, 32'h0,          0, 1, 0, 0, 32'hBEEFAB44, 32'h0,        32'h40);
        cyc("b2b_sb_rd",  0, 1, 1, 2'b00, 0, 32'h40, 32'h00000011,   1, 1, 0, 0, 32'h0,        32'h0,        32'h40);
        cyc("b2b_sb_wr",  0, 1, 1, 2'b00, 0, 32'h40, 32'h00000011,   0, 0, 1, 0, 32'h0,        32'hBEEFAB11, 32'h40);
        cyc("b2b_lw",     0, 1, 0, 2'b10, 0, 32'h40, 32'h0,          0, 1, 0, 0, 32'hBEEFAB11, 32'h0,        32'h40);
        cyc("lh_42_neg",  0, 1, 0, 2'b01, 0, 32'h42, 32'h0,          0, 1, 0, 0, 32'hFFFFBEEF, 32'h0,        32'h40);
        cyc("lbu_41",     0, 1, 0, 2'b00, 1, 32'h41, 32'h0,          0, 1, 0, 0, 32'h000000AB, 32'h0,        32'h40);
        cyc("lb_40_pos",  0, 1, 0, 2'b00, 0, 32'h40, 32'h0,          0, 1, 0, 0, 32'h00000011, 32'h0,        32'h40);
        cyc("end_idle",   0, 0, 0, 2'b00, 0, 32'h0,  32'h0,          0, 0, 0, 0, 32'h0,        32'h0,        32'h0);

        @(posedge Clk);
        @(posedge Clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
        end
        mem_check("mem_40_final", 16, 32'hBEEFAB11);
        mem_check("mem_44_final", 17, 32'h12345678);
        mem_check("mem_48_untouched", 18, 32'h00000000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
